// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: copies an image from a boot source into memory, optionally read-back
// verifies it (BOOT_SEQ_VERIFY_EN), then holds the CPU in reset for P_HOLD_CYCLES cycles.
module boot_seq_ctrl #(
  parameter int P_HOLD_CYCLES = 5,
  parameter bit P_SWAP        = 1'b1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic [31:0] src_base,
  input  logic [31:0] dst_base,
  input  logic [15:0] num_words,
  output logic        src_req,
  output logic [31:0] src_addr,
  input  logic        src_ack,
  input  logic [31:0] src_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        cpu_resetn,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] mismatch_cnt
);

  typedef enum logic [3:0] {
    IDLE, RD, WR, VRD_S, VRD_M, CMP, HOLD, RUN, ERR
  } state_t;

  localparam logic [31:0] HOLD_LAST = 32'(P_HOLD_CYCLES);

  state_t      state_q, state_n;
  logic [15:0] idx_q, idx_n;
  logic [31:0] src_base_q, src_base_n;
  logic [31:0] dst_base_q, dst_base_n;
  logic [15:0] num_q, num_n;
  logic [31:0] src_word_q, src_word_n;
  logic [31:0] mem_word_q, mem_word_n;
  logic [15:0] mismatch_n;
  logic [31:0] hold_q, hold_n;

  logic        src_req_n, mem_req_n, mem_we_n;
  logic [31:0] src_addr_n, mem_addr_n, mem_wdata_n;
  logic [3:0]  mem_wstrb_n;
  logic        cpu_resetn_n, busy_n, done_n, error_n;

  function automatic logic [31:0] fmt_word(input logic [31:0] w);
    if (P_SWAP) return {w[7:0], w[15:8], w[23:16], w[31:24]};
    else        return w;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    src_base_n = src_base_q;
    dst_base_n = dst_base_q;
    num_n      = num_q;
    src_word_n = src_word_q;
    mem_word_n = mem_word_q;
    mismatch_n = mismatch_cnt;
    hold_n     = '0;

    case (state_q)
      IDLE, RUN, ERR: begin
        if (start) begin
          src_base_n = src_base;
          dst_base_n = dst_base;
          num_n      = num_words;
          idx_n      = '0;
          mismatch_n = '0;
          state_n    = (num_words == 16'd0) ? HOLD : RD;
        end
      end
      RD: begin
        if (src_ack && src_req) begin
          src_word_n = fmt_word(src_rdata);
          state_n    = WR;
        end
      end
      WR: begin
        if (mem_ack && mem_req) begin
          if (idx_q == num_q - 16'd1) begin
            idx_n = '0;
`ifdef BOOT_SEQ_VERIFY_EN
            state_n = VRD_S;
`else
            state_n = HOLD;
`endif
          end else begin
            idx_n   = idx_q + 16'd1;
            state_n = RD;
          end
        end
      end
`ifdef BOOT_SEQ_VERIFY_EN
      VRD_S: begin
        if (src_ack && src_req) begin
          src_word_n = fmt_word(src_rdata);
          state_n    = VRD_M;
        end
      end
      VRD_M: begin
        if (mem_ack && mem_req) begin
          mem_word_n = mem_rdata;
          state_n    = CMP;
        end
      end
      CMP: begin
        if ((src_word_q != mem_word_q) && (mismatch_cnt != 16'hFFFF))
          mismatch_n = mismatch_cnt + 16'd1;
        if (idx_q == num_q - 16'd1) begin
          state_n = (mismatch_n != 16'd0) ? ERR : HOLD;
        end else begin
          idx_n   = idx_q + 16'd1;
          state_n = VRD_S;
        end
      end
`endif
      HOLD: begin
        if (hold_q == HOLD_LAST) state_n = RUN;
        else                     hold_n  = hold_q + 32'd1;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered from the next state so a request is visible in the
    // first cycle of its state and stays stable until the state advances.
    src_req_n    = (state_n == RD) || (state_n == VRD_S);
    mem_req_n    = (state_n == WR) || (state_n == VRD_M);
    mem_we_n     = (state_n == WR);
    src_addr_n   = src_req_n ? src_base_n + {14'd0, idx_n, 2'b00} : '0;
    mem_addr_n   = mem_req_n ? dst_base_n + {14'd0, idx_n, 2'b00} : '0;
    mem_wdata_n  = mem_we_n ? src_word_n : '0;
    mem_wstrb_n  = mem_we_n ? 4'hF : 4'h0;
    cpu_resetn_n = (state_n == RUN);
    done_n       = (state_n == RUN);
    busy_n       = !((state_n == IDLE) || (state_n == RUN) || (state_n == ERR));
`ifdef BOOT_SEQ_VERIFY_EN
    error_n      = (state_n == ERR);
`else
    error_n      = 1'b0;
`endif
  end

`ifndef BOOT_SEQ_VERIFY_EN
  // Read-back data has no consumer when verification is compiled out.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
`endif

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      src_base_q   <= '0;
      dst_base_q   <= '0;
      num_q        <= '0;
      src_word_q   <= '0;
      mem_word_q   <= '0;
      hold_q       <= '0;
      src_req      <= 1'b0;
      src_addr     <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= 4'h0;
      cpu_resetn   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      state_q      <= state_n;
      idx_q        <= idx_n;
      src_base_q   <= src_base_n;
      dst_base_q   <= dst_base_n;
      num_q        <= num_n;
      src_word_q   <= src_word_n;
      mem_word_q   <= mem_word_n;
      hold_q       <= hold_n;
      src_req      <= src_req_n;
      src_addr     <= src_addr_n;
      mem_req      <= mem_req_n;
      mem_we       <= mem_we_n;
      mem_addr     <= mem_addr_n;
      mem_wdata    <= mem_wdata_n;
      mem_wstrb    <= mem_wstrb_n;
      cpu_resetn   <= cpu_resetn_n;
      busy         <= busy_n;
      done         <= done_n;
      error        <= error_n;
      mismatch_cnt <= mismatch_n;
    end
  end

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Self-checking bench for boot_seq_ctrl: table-driven image checks plus directed
// sequences for hold timing, reboot, abort, address wrap and busy-start filtering.
module tb_boot_seq_ctrl;

  localparam int HOLD   = 5;
  localparam int BUDGET = 5000;
`ifdef BOOT_SEQ_VERIFY_EN
  localparam int VER_CYC = 5;
`else
  localparam int VER_CYC = 0;
`endif

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_base = '0, dst_base = '0;
  logic [15:0] num_words = '0;
  logic        src_req, mem_req, mem_we, cpu_resetn, busy, done, error;
  logic [31:0] src_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [15:0] mismatch_cnt;
  logic        src_ack = 1'b0, mem_ack = 1'b0;
  logic [31:0] src_rdata = '0, mem_rdata = '0;

  boot_seq_ctrl #(.P_HOLD_CYCLES(HOLD), .P_SWAP(1'b1)) dut (
    .aclk(aclk), .areset(areset), .start(start),
    .src_base(src_base), .dst_base(dst_base), .num_words(num_words),
    .src_req(src_req), .src_addr(src_addr), .src_ack(src_ack), .src_rdata(src_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cpu_resetn(cpu_resetn), .busy(busy), .done(done), .error(error),
    .mismatch_cnt(mismatch_cnt)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave models and bookkeeping; only the blocks below write their own state.
  logic [31:0] src_img [logic [31:0]];
  logic [31:0] mem_img [logic [31:0]];
  bit          wr_hits [logic [31:0]];
  int          dly_max = 0;
  bit          corrupt = 1'b0;
  int          clr_gen = 0, seen_gen = 0;
  int          wr_count = 0, double_wr = 0, proto_err = 0;
  int          s_cnt = 0, s_dly = 0, m_cnt = 0, m_dly = 0;

  always @(posedge aclk) begin
    if (clr_gen != seen_gen) begin
      mem_img.delete();
      wr_hits.delete();
      wr_count = 0;
      double_wr = 0;
      seen_gen = clr_gen;
    end
    if (src_ack) src_ack <= 1'b0;
    else if (src_req) begin
      if (s_cnt >= s_dly) begin
        src_ack   <= 1'b1;
        src_rdata <= src_img.exists(src_addr) ? src_img[src_addr] : 32'h0;
        s_cnt = 0;
        s_dly = int'($urandom_range(dly_max, 0));
      end else s_cnt++;
    end else s_cnt = 0;

    if (mem_ack) mem_ack <= 1'b0;
    else if (mem_req) begin
      if (m_cnt >= m_dly) begin
        mem_ack <= 1'b1;
        if (mem_we) begin
          if (mem_wstrb != 4'hF) proto_err++;
          if (wr_hits.exists(mem_addr)) double_wr++;
          wr_hits[mem_addr] = 1'b1;
          mem_img[mem_addr] = mem_wdata;
          wr_count++;
        end else begin
          if (mem_wstrb != 4'h0) proto_err++;
          mem_rdata <= (mem_img.exists(mem_addr) ? mem_img[mem_addr] : 32'h0) ^
                       ((corrupt && mem_addr == 32'h108) ? 32'h0000_0100 : 32'h0);
        end
        m_cnt = 0;
        m_dly = int'($urandom_range(dly_max, 0));
      end else m_cnt++;
    end else m_cnt = 0;
  end

  // Request stability / exclusivity monitor, sampled mid-cycle.
  int          stab_err = 0, req_rises = 0;
  logic        s_hold = 0, m_hold = 0, s_prev = 0, m_prev = 0, m_we_s = 0;
  logic [31:0] s_a = '0, m_a = '0, m_d = '0;

  always @(negedge aclk) begin
    if (s_hold && src_req && src_addr != s_a) stab_err++;
    if (m_hold && mem_req && (mem_addr != m_a || mem_wdata != m_d || mem_we != m_we_s)) stab_err++;
    if (src_req && mem_req) stab_err++;
    if (src_req && !s_prev) req_rises++;
    if (mem_req && !m_prev) req_rises++;
    s_hold = src_req && !src_ack;
    m_hold = mem_req && !mem_ack;
    s_a = src_addr; m_a = mem_addr; m_d = mem_wdata; m_we_s = mem_we;
    s_prev = src_req; m_prev = mem_req;
  end

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem_img.exists(a) ? mem_img[a] : 32'hBAD0_BAD0;
  endfunction

  // Pulses start and counts edges until cpu_resetn rises or error is raised.
  task automatic run_boot(input logic [31:0] sb, input logic [31:0] db, input logic [15:0] n,
                          input bit spurious, output int cycles);
    clr_gen++;
    src_base = sb; dst_base = db; num_words = n; start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    check("cpu_resetn_low_after_start", {31'd0, cpu_resetn}, 32'd0);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    cycles = 0;
    while (!cpu_resetn && !error && cycles < BUDGET) begin
      if (spurious && (cycles == 3 || cycles == 7)) begin
        start = 1'b1; src_base = 32'h3000; dst_base = 32'h200; num_words = 16'd1;
      end
      @(posedge aclk); #1;
      start = 1'b0;
      cycles++;
    end
    if (cycles >= BUDGET) check("boot_timeout", cycles, 32'd0);
  endtask

  typedef struct {
    logic [31:0] src_word;
    logic [31:0] dst_addr;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int cyc;
    int errs;
    int rises0;
    logic [31:0] w;

    vecs[0] = '{32'h1122_3344, 32'h0000_0100, 32'h4433_2211};
    vecs[1] = '{32'hAABB_CCDD, 32'h0000_0104, 32'hDDCC_BBAA};
    vecs[2] = '{32'h0000_0000, 32'h0000_0108, 32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_010C, 32'hFFFF_FFFF};
    vecs[4] = '{32'h0102_0304, 32'hFFFF_FFF8, 32'h0403_0201};
    vecs[5] = '{32'hCAFE_F00D, 32'hFFFF_FFFC, 32'h0DF0_FECA};
    vecs[6] = '{32'h8000_0001, 32'h0000_0000, 32'h0100_0080};

    // Reset, with start asserted in the same cycles: reset must win.
    areset = 1'b1; start = 1'b1; num_words = 16'd4;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_src_req", {31'd0, src_req}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_src_addr", src_addr, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
    check("rst_busy_done_error", {29'd0, busy, done, error}, 32'd0);
    check("rst_mismatch_cnt", {16'd0, mismatch_cnt}, 32'd0);
    areset = 1'b0; start = 1'b0;
    @(posedge aclk); #1;
    check("idle_after_reset_busy", {31'd0, busy}, 32'd0);

    // 4-word byte-swapped copy, 0-wait slaves.
    for (int i = 0; i < 4; i++) src_img[32'h1000 + 32'(4 * i)] = vecs[i].src_word;
    run_boot(32'h1000, 32'h100, 16'd4, 1'b0, cyc);
    check("copy4_cycles", cyc, 32'(4 * 4 + VER_CYC * 4 + HOLD + 1));
    check("copy4_done", {30'd0, done, cpu_resetn}, 32'd3);
    check("copy4_busy_error", {30'd0, busy, error}, 32'd0);
    check("copy4_mismatch", {16'd0, mismatch_cnt}, 32'd0);
    check("copy4_writes", wr_count, 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("copy4_word%0d", i), rd_mem(vecs[i].dst_addr), vecs[i].exp_word);

    // Zero-length boot from RUN: no requests, only the hold period.
    rises0 = req_rises;
    run_boot(32'h1000, 32'h100, 16'd0, 1'b0, cyc);
    check("zero_cycles", cyc, 32'(HOLD + 1));
    check("zero_no_requests", req_rises - rises0, 32'd0);
    check("zero_done", {31'd0, done}, 32'd1);

    // Destination wrapping past 2^32, with start pulses while busy.
    for (int i = 4; i < 7; i++) src_img[32'h2000 + 32'(4 * (i - 4))] = vecs[i].src_word;
    run_boot(32'h2000, 32'hFFFF_FFF8, 16'd3, 1'b1, cyc);
    check("wrap_cycles", cyc, 32'(3 * 4 + VER_CYC * 3 + HOLD + 1));
    check("wrap_writes", wr_count, 32'd3);
    check("wrap_no_spurious_write", {31'd0, wr_hits.exists(32'h200) ? 1'b1 : 1'b0}, 32'd0);
    for (int i = 4; i < 7; i++) check($sformatf("wrap_word%0d", i - 4), rd_mem(vecs[i].dst_addr), vecs[i].exp_word);

    // 64 words with random 0-7 cycle ack delays on both ports.
    dly_max = 7;
    for (int i = 0; i < 64; i++) src_img[32'h4000 + 32'(4 * i)] = $urandom;
    run_boot(32'h4000, 32'h8000, 16'd64, 1'b0, cyc);
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      w = src_img[32'h4000 + 32'(4 * i)];
      if (rd_mem(32'h8000 + 32'(4 * i)) !== {<<8{w}}) errs++;
    end
    check("rand_image_errors", errs, 32'd0);
    check("rand_writes", wr_count, 32'd64);
    check("rand_double_writes", double_wr, 32'd0);
    check("rand_done", {31'd0, done}, 32'd1);
    dly_max = 0;

    // Abort with reset during WR of word 2, then a clean reboot.
    clr_gen++;
    src_base = 32'h1000; dst_base = 32'h100; num_words = 16'd4; start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(mem_req && mem_we && mem_addr == 32'h108) && cyc < 100) begin
      @(posedge aclk); #1;
      cyc++;
    end
    check("abort_reached_wr2", {31'd0, (cyc < 100) ? 1'b1 : 1'b0}, 32'd1);
    areset = 1'b1;
    @(posedge aclk); #1;
    check("abort_mem_req", {31'd0, mem_req}, 32'd0);
    check("abort_src_req", {31'd0, src_req}, 32'd0);
    check("abort_idle", {29'd0, busy, done, cpu_resetn}, 32'd0);
    areset = 1'b0;
    @(posedge aclk); #1;
    run_boot(32'h1000, 32'h100, 16'd4, 1'b0, cyc);
    check("reboot_done", {31'd0, done}, 32'd1);
    for (int i = 0; i < 4; i++) check($sformatf("reboot_word%0d", i), rd_mem(vecs[i].dst_addr), vecs[i].exp_word);

`ifdef BOOT_SEQ_VERIFY_EN
    // Corrupted read-back at 0x108 ends in ERR; a clean model then reaches RUN.
    corrupt = 1'b1;
    run_boot(32'h1000, 32'h100, 16'd4, 1'b0, cyc);
    check("verify_error", {31'd0, error}, 32'd1);
    check("verify_mismatch_cnt", {16'd0, mismatch_cnt}, 32'd1);
    check("verify_not_done", {30'd0, done, busy}, 32'd0);
    repeat (10) @(posedge aclk);
    #1;
    check("verify_cpu_held", {31'd0, cpu_resetn}, 32'd0);
    corrupt = 1'b0;
    run_boot(32'h1000, 32'h100, 16'd4, 1'b0, cyc);
    check("verify_clean_done", {30'd0, done, error}, 32'd2);
    check("verify_clean_mismatch", {16'd0, mismatch_cnt}, 32'd0);
`else
    check("noverify_error_tied", {31'd0, error}, 32'd0);
    check("noverify_mismatch_tied", {16'd0, mismatch_cnt}, 32'd0);
`endif

    check("request_stability_errors", stab_err, 32'd0);
    check("strobe_errors", proto_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
